// File: rtl/dino_pkg.sv
// Shared definitions for the obstacle scheduler and the sprite renderers.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned OBJ_W    = 60;
  localparam int unsigned POS_W    = 10;
  localparam int unsigned SPEED_W  = 4;

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; shifts toward the MSB.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  assign w_fb = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[14:0], w_fb};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/obstacle_scheduler.sv
// Run/crash sequencer: frame-tick scroll of obstacle slots, pseudo-random
// spawn gaps and time-based speed ramp.
module obstacle_scheduler #(
  parameter int unsigned NUM_SLOTS   = 3,
  parameter int unsigned SCREEN_W    = dino_pkg::SCREEN_W,
  parameter int unsigned OBJ_W       = dino_pkg::OBJ_W,
  parameter int unsigned MIN_GAP     = 40,
  parameter int unsigned SPEED_INIT  = 2,
  parameter int unsigned SPEED_MAX   = 12,
  parameter int unsigned RAMP_FRAMES = 600,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                                  clk,
  input  logic                                  RESET_n,
  input  logic                                  fresh,
  input  logic                                  start,
  input  logic                                  collide,
  output logic                                  game_status,
  output logic [dino_pkg::SPEED_W-1:0]          speed,
  output logic [NUM_SLOTS-1:0]                  slot_active,
  output logic [NUM_SLOTS*dino_pkg::POS_W-1:0]  slot_pos,
  output logic [15:0]                           score
);

  import dino_pkg::*;

  localparam int unsigned GAP_W  = 16;
  localparam int unsigned RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  typedef logic [POS_W:0]     ext_t;
  typedef logic [SPEED_W-1:0] spd_t;
  typedef logic [GAP_W-1:0]   gap_t;
  typedef logic [RAMP_W-1:0]  ramp_t;

  localparam ext_t  RETIRE_AT    = ext_t'(SCREEN_W + OBJ_W);
  localparam spd_t  SPEED_INIT_V = spd_t'(SPEED_INIT);
  localparam spd_t  SPEED_MAX_V  = spd_t'(SPEED_MAX);
  localparam gap_t  MIN_GAP_V    = gap_t'(MIN_GAP);
  localparam ramp_t RAMP_LAST    = ramp_t'(RAMP_FRAMES - 1);

  state_t                 r_state, w_state;
  logic                   r_fresh_d;
  logic                   r_status;
  spd_t                   r_speed, w_speed;
  logic [NUM_SLOTS-1:0]   r_active, w_active;
  logic [POS_W-1:0]       r_pos [NUM_SLOTS];
  logic [POS_W-1:0]       w_pos [NUM_SLOTS];
  logic [15:0]            r_score, w_score;
  ramp_t                  r_ramp, w_ramp;
  gap_t                   r_gap, w_gap;

  logic                   w_tick;
  ext_t                   w_sum;
  logic                   w_spawned;
  logic [15:0]            w_lfsr;
  logic [9:0]             w_lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (RESET_n),
    .i_en    (1'b1),
    .o_state (w_lfsr)
  );

  assign w_lfsr_unused = w_lfsr[15:6];
  assign w_tick        = r_fresh_d & ~fresh;

  always_comb begin
    w_state   = r_state;
    w_speed   = r_speed;
    w_active  = r_active;
    w_pos     = r_pos;
    w_score   = r_score;
    w_ramp    = r_ramp;
    w_gap     = r_gap;
    w_sum     = '0;
    w_spawned = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state = RUN;
          w_gap   = MIN_GAP_V;
        end
      end
      RUN: begin
        if (collide) begin
          w_state = OVER;
        end else if (w_tick) begin
          for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (r_active[i]) begin
              w_sum = ext_t'(r_pos[i]) + ext_t'(r_speed);
              if (w_sum >= RETIRE_AT) begin
                w_active[i] = 1'b0;
                w_pos[i]    = '0;
              end else begin
                w_pos[i] = w_sum[POS_W-1:0];
              end
            end
          end
          if (r_score != '1) begin
            w_score = r_score + 16'd1;
          end
          if (r_ramp == RAMP_LAST) begin
            w_ramp = '0;
            if (r_speed < SPEED_MAX_V) begin
              w_speed = r_speed + spd_t'(1);
            end
          end else begin
            w_ramp = r_ramp + ramp_t'(1);
          end
          // Post-decrement zero test; w_active already reflects slots retired this tick.
          if (r_gap != '0) begin
            w_gap = r_gap - gap_t'(1);
          end
          if ((w_gap == '0) && !(&w_active)) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              if (!w_spawned && !w_active[i]) begin
                w_active[i] = 1'b1;
                w_pos[i]    = '0;
                w_spawned   = 1'b1;
              end
            end
            w_gap = MIN_GAP_V + gap_t'(w_lfsr[5:0]);
          end
        end
      end
      OVER: begin
        if (start) begin
          w_state  = RUN;
          w_speed  = SPEED_INIT_V;
          w_active = '0;
          w_pos    = '{default: '0};
          w_score  = '0;
          w_ramp   = '0;
          w_gap    = MIN_GAP_V;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= IDLE;
      r_fresh_d <= 1'b1;
      r_status  <= 1'b0;
      r_speed   <= SPEED_INIT_V;
      r_active  <= '0;
      r_pos     <= '{default: '0};
      r_score   <= '0;
      r_ramp    <= '0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state;
      r_fresh_d <= fresh;
      r_status  <= (w_state == RUN);
      r_speed   <= w_speed;
      r_active  <= w_active;
      r_pos     <= w_pos;
      r_score   <= w_score;
      r_ramp    <= w_ramp;
      r_gap     <= w_gap;
    end
  end

  always_comb begin
    slot_pos = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_pos[i*POS_W +: POS_W] = r_pos[i];
    end
  end

  assign game_status = r_status;
  assign speed       = r_speed;
  assign slot_active = r_active;
  assign score       = r_score;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: default instance plus a fast-ramp instance.
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        RESET_n;
  logic        fresh;
  logic        start;
  logic        collide;

  logic        gs_d, gs_r;
  logic [3:0]  sp_d, sp_r;
  logic [2:0]  act_d, act_r;
  logic [29:0] pos_d, pos_r;
  logic [15:0] sc_d, sc_r;

  logic [15:0] m_lfsr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  obstacle_scheduler u_dut (
    .clk         (clk),
    .RESET_n     (RESET_n),
    .fresh       (fresh),
    .start       (start),
    .collide     (collide),
    .game_status (gs_d),
    .speed       (sp_d),
    .slot_active (act_d),
    .slot_pos    (pos_d),
    .score       (sc_d)
  );

  obstacle_scheduler #(.RAMP_FRAMES(4)) u_ramp (
    .clk         (clk),
    .RESET_n     (RESET_n),
    .fresh       (fresh),
    .start       (start),
    .collide     (collide),
    .game_status (gs_r),
    .speed       (sp_r),
    .slot_active (act_r),
    .slot_pos    (pos_r),
    .score       (sc_r)
  );

  // Reference LFSR: x^16 + x^14 + x^13 + x^11, tap n maps to bit n-1.
  always @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: fresh high for a cycle, then low; returns the LFSR value seen on the tick edge.
  task automatic do_tick(output logic [15:0] l);
    fresh = 1'b1;
    @(posedge clk); #1;
    fresh = 1'b0;
    l = m_lfsr;
    @(posedge clk); #1;
  endtask

  logic [15:0] l;
  int          mpos [3];
  bit          mact [3];
  int          next_due;
  int          found;
  logic [31:0] exp_act, exp_pos;

  initial begin
    RESET_n = 1'b0; fresh = 1'b0; start = 1'b0; collide = 1'b0;
    for (int s = 0; s < 3; s++) begin mpos[s] = 0; mact[s] = 0; end
    next_due = 40;
    #12;
    check("rst_status", 32'(gs_d), 0);
    check("rst_speed", 32'(sp_d), 2);
    check("rst_active", 32'(act_d), 0);
    check("rst_pos", 32'(pos_d), 0);
    check("rst_score", 32'(sc_d), 0);

    @(posedge clk); #1;
    RESET_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_status", 32'(gs_d), 1);
    check("start_status_ramp", 32'(gs_r), 1);

    for (int t = 1; t <= 390; t++) begin
      do_tick(l);
      for (int s = 0; s < 3; s++) begin
        if (mact[s]) begin
          mpos[s] += 2;
          if (mpos[s] >= 700) begin mact[s] = 0; mpos[s] = 0; end
        end
      end
      if (t >= next_due) begin
        found = -1;
        for (int s = 0; s < 3; s++) if (found < 0 && !mact[s]) found = s;
        if (found >= 0) begin
          mact[found] = 1; mpos[found] = 0;
          next_due = t + 40 + int'(l[5:0]);
        end
      end
      exp_act = '0; exp_pos = '0;
      for (int s = 0; s < 3; s++) begin
        if (mact[s]) exp_act[s] = 1'b1;
        exp_pos = exp_pos | (32'(mpos[s]) << (10 * s));
      end
      check("run_active", 32'(act_d), exp_act);
      check("run_pos", 32'(pos_d), exp_pos);
      check("run_score", 32'(sc_d), 32'(t));
      if (t == 3)  check("ramp_t3", 32'(sp_r), 2);
      if (t == 4)  check("ramp_t4", 32'(sp_r), 3);
      if (t == 39) check("ramp_t39", 32'(sp_r), 11);
      if (t == 40) begin
        check("ramp_t40", 32'(sp_r), 12);
        check("first_spawn_active", 32'(act_d), 1);
        check("first_spawn_pos", 32'(pos_d), 0);
      end
      if (t == 44) check("ramp_sat", 32'(sp_r), 12);
      if (t == 389) begin
        check("full_active", 32'(act_d), 7);
        check("slot0_698", 32'(pos_d[9:0]), 698);
        check("speed_default", 32'(sp_d), 2);
      end
      if (t == 390) begin
        check("reuse_active", 32'(act_d), 7);
        check("reuse_pos0", 32'(pos_d[9:0]), 0);
      end
    end

    fresh = 1'b1;
    @(posedge clk); #1;
    fresh = 1'b0; collide = 1'b1;
    @(posedge clk); #1;
    collide = 1'b0;
    check("crash_status", 32'(gs_d), 0);
    check("crash_score", 32'(sc_d), 390);
    check("crash_pos", 32'(pos_d), exp_pos);
    check("crash_active", 32'(act_d), exp_act);
    for (int k = 0; k < 3; k++) begin
      do_tick(l);
      check("over_score", 32'(sc_d), 390);
      check("over_pos", 32'(pos_d), exp_pos);
    end
    check("over_speed_ramp", 32'(sp_r), 12);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_status", 32'(gs_d), 1);
    check("restart_speed_ramp", 32'(sp_r), 2);
    check("restart_score", 32'(sc_d), 0);
    check("restart_active", 32'(act_d), 0);
    check("restart_pos", 32'(pos_d), 0);
    for (int k = 0; k < 5; k++) do_tick(l);
    check("rerun_score", 32'(sc_d), 5);
    check("rerun_active", 32'(act_d), 0);

    fresh = 1'b1;
    @(posedge clk); #1;
    RESET_n = 1'b0; fresh = 1'b0;
    #1;
    check("midrst_status", 32'(gs_d), 0);
    check("midrst_score", 32'(sc_d), 0);
    check("midrst_speed_ramp", 32'(sp_r), 2);
    check("midrst_active", 32'(act_d), 0);
    repeat (2) begin @(posedge clk); #1; end
    RESET_n = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("post_rst_status", 32'(gs_d), 1);
    check("post_rst_score", 32'(sc_d), 0);
    repeat (4) begin @(posedge clk); #1; end
    check("no_tick_low", 32'(sc_d), 0);
    do_tick(l);
    check("tick_after_high", 32'(sc_d), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
